// File: rtl/elelock_seq_ctrl_if.sv
// Key-pad and lock-actuator signal bundle for the sequenced code-entry lock.
// The master side drives the key switches and the close request; the slave side drives the lock status.
interface elelock_seq_ctrl_if;
  logic [9:0] tenkey;
  logic       close;
  logic       lock;
  logic       lockout;
  logic       err;
  logic [2:0] digit_cnt;

  modport master (
    output tenkey, close,
    input  lock, lockout, err, digit_cnt
  );

  modport slave (
    input  tenkey, close,
    output lock, lockout, err, digit_cnt
  );
endinterface

// File: rtl/elelock_seq_ctrl.sv
// Four-digit code-entry lock controller: debounced one-hot key presses build a code that is
// checked against SECRET, with a lockout after repeated failures and an idle-entry timeout.
module elelock_seq_ctrl #(
  parameter logic [15:0] SECRET      = 16'h5963,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCKOUT_CYC = 1000,
  parameter int          TIMEOUT_CYC = 500
) (
  input  logic               clk,
  input  logic               reset,
  elelock_seq_ctrl_if.slave  bus
);

  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYC);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC);

  localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);
  localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCKOUT_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);

  // A secret containing a non-BCD nibble can never be entered.
  localparam bit SECRET_VALID = (SECRET[15:12] <= 4'd9) && (SECRET[11:8] <= 4'd9) &&
                                (SECRET[7:4] <= 4'd9) && (SECRET[3:0] <= 4'd9);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    ENTRY    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [9:0]          tenkey_q_reg;
  logic [3:0]          digit_reg [3];
  logic [2:0]          cnt_reg, cnt_next;
  logic [FAIL_W-1:0]   fail_reg, fail_next;
  logic [LOCK_W-1:0]   lock_tmr_reg, lock_tmr_next;
  logic [IDLE_W-1:0]   idle_reg, idle_next;
  logic                err_reg, err_next;
  logic                digit_store;

  logic [3:0]          enc_term [10];
  logic [3:0]          key_digit;
  logic                key_onehot;
  logic                press;
  logic [2:0]          digit_hit;
  logic                code_match;
  logic [FAIL_W-1:0]   fail_inc;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_enc
      assign enc_term[gi] = bus.tenkey[gi] ? 4'(gi) : 4'd0;
    end
    for (gi = 0; gi < 3; gi++) begin : g_hit
      assign digit_hit[gi] = (digit_reg[gi] == SECRET[15 - 4*gi -: 4]);
    end
  endgenerate

  always_comb begin
    key_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      key_digit = key_digit | enc_term[i];
    end
  end

  // A press is a clean one-hot sample directly following an all-zero sample.
  assign key_onehot = (bus.tenkey != 10'd0) && ((bus.tenkey & (bus.tenkey - 10'd1)) == 10'd0);
  assign press      = key_onehot && (tenkey_q_reg == 10'd0);
  assign code_match = SECRET_VALID && (&digit_hit) && (key_digit == SECRET[3:0]);
  assign fail_inc   = fail_reg + FAIL_W'(1);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    fail_next     = fail_reg;
    lock_tmr_next = lock_tmr_reg;
    idle_next     = idle_reg;
    err_next      = 1'b0;
    digit_store   = 1'b0;

    case (state_reg)
      LOCKED: begin
        if (press) begin
          digit_store = 1'b1;
          cnt_next    = 3'd1;
          idle_next   = '0;
          state_next  = ENTRY;
        end
      end

      ENTRY: begin
        if (press) begin
          idle_next = '0;
          if (cnt_reg < 3'd3) begin
            digit_store = 1'b1;
            cnt_next    = cnt_reg + 3'd1;
          end else begin
            cnt_next = 3'd0;
            if (code_match) begin
              fail_next  = '0;
              state_next = UNLOCKED;
            end else begin
              err_next = 1'b1;
              if (fail_inc == FAIL_LIMIT) begin
                fail_next     = '0;
                lock_tmr_next = LOCK_LOAD;
                state_next    = LOCKOUT;
              end else begin
                fail_next  = fail_inc;
                state_next = LOCKED;
              end
            end
          end
        end else if (idle_reg == IDLE_LAST) begin
          idle_next  = '0;
          cnt_next   = 3'd0;
          state_next = LOCKED;
        end else begin
          idle_next = idle_reg + IDLE_W'(1);
        end
      end

      UNLOCKED: begin
        if (bus.close) begin
          state_next = LOCKED;
        end
      end

      LOCKOUT: begin
        if (lock_tmr_reg == '0) begin
          state_next = LOCKED;
        end else begin
          lock_tmr_next = lock_tmr_reg - LOCK_W'(1);
        end
      end

      default: state_next = LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= LOCKED;
      tenkey_q_reg <= '0;
      cnt_reg      <= '0;
      fail_reg     <= '0;
      lock_tmr_reg <= '0;
      idle_reg     <= '0;
      err_reg      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        digit_reg[i] <= 4'd0;
      end
    end else begin
      state_reg    <= state_next;
      tenkey_q_reg <= bus.tenkey;
      cnt_reg      <= cnt_next;
      fail_reg     <= fail_next;
      lock_tmr_reg <= lock_tmr_next;
      idle_reg     <= idle_next;
      err_reg      <= err_next;
      for (int i = 0; i < 3; i++) begin
        if (digit_store && (cnt_reg == 3'(i))) begin
          digit_reg[i] <= key_digit;
        end
      end
    end
  end

  assign bus.lock      = (state_reg != UNLOCKED);
  assign bus.lockout   = (state_reg == LOCKOUT);
  assign bus.err       = err_reg;
  assign bus.digit_cnt = cnt_reg;

endmodule

// File: tb/tb_elelock_seq_ctrl.sv
// Self-checking bench for elelock_seq_ctrl: directed scenarios plus randomized key traffic
// compared against a queue-based behavioural model of the lock.
module tb_elelock_seq_ctrl;
  localparam logic [15:0] SECRET      = 16'h5963;
  localparam int          MAX_FAIL    = 3;
  localparam int          LOCKOUT_CYC = 20;
  localparam int          TIMEOUT_CYC = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  elelock_seq_ctrl_if bus();

  elelock_seq_ctrl #(
    .SECRET      (SECRET),
    .MAX_FAIL    (MAX_FAIL),
    .LOCKOUT_CYC (LOCKOUT_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: entered digits live in a queue, lockout is a remaining-cycle count.
  bit         m_unlocked;
  int         m_lock_left;
  int         m_digits[$];
  int         m_fails;
  int         m_idle;
  bit         m_err;
  logic [9:0] m_prev;

  function automatic logic [9:0] key(input int d);
    logic [9:0] one = 10'd1;
    return one << d;
  endfunction

  function automatic int secret_digit(input int i);
    logic [15:0] s = SECRET;
    return int'((s >> (12 - 4*i)) & 16'h000F);
  endfunction

  function automatic logic [5:0] model_out();
    return {~m_unlocked, (m_lock_left > 0), m_err, 3'(m_digits.size())};
  endfunction

  task automatic model_step(input logic [9:0] k, input bit c, input bit r);
    int d;
    int code;
    bit pr;
    if (r) begin
      m_unlocked = 0; m_lock_left = 0; m_digits.delete();
      m_fails = 0; m_idle = 0; m_err = 0; m_prev = '0;
      return;
    end
    pr = ($countones(k) == 1) && (m_prev == 10'd0);
    d = 0;
    for (int i = 0; i < 10; i++) if (k[i]) d = i;
    m_prev = k;
    m_err = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
    end else if (m_unlocked) begin
      if (c) m_unlocked = 0;
    end else if (pr) begin
      m_idle = 0;
      if (m_digits.size() < 3) begin
        m_digits.push_back(d);
      end else begin
        code = m_digits[0]*4096 + m_digits[1]*256 + m_digits[2]*16 + d;
        m_digits.delete();
        if (code == int'(SECRET)) begin
          m_unlocked = 1;
          m_fails = 0;
        end else begin
          m_err = 1;
          m_fails++;
          if (m_fails == MAX_FAIL) begin
            m_lock_left = LOCKOUT_CYC;
            m_fails = 0;
          end
        end
      end
    end else if (m_digits.size() > 0) begin
      m_idle++;
      if (m_idle == TIMEOUT_CYC) begin
        m_digits.delete();
        m_idle = 0;
      end
    end
  endtask

  task automatic tick(input logic [9:0] k, input bit c, input bit r);
    bus.tenkey = k;
    bus.close  = c;
    reset      = r;
    @(posedge clk);
    model_step(k, c, r);
    #1;
  endtask

  task automatic enter3(input int a, input int b, input int c);
    tick(key(a), 0, 0); tick('0, 0, 0);
    tick(key(b), 0, 0); tick('0, 0, 0);
    tick(key(c), 0, 0); tick('0, 0, 0);
  endtask

  task automatic test_reset();
    tick('0, 0, 1);
    tests_run++; if (bus.lock !== 1'b1) begin tests_failed++; $display("FAIL reset_lock: got %b want 1", bus.lock); end
    tests_run++; if (bus.lockout !== 1'b0) begin tests_failed++; $display("FAIL reset_lockout: got %b want 0", bus.lockout); end
    tests_run++; if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", bus.err); end
    tests_run++; if (bus.digit_cnt !== 3'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", bus.digit_cnt); end
    tick('0, 0, 0);
  endtask

  task automatic test_unlock();
    int seq[4]  = '{5, 9, 6, 3};
    int want[4] = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      tick(key(seq[i]), 0, 0);
      tests_run++;
      if (bus.digit_cnt !== 3'(want[i])) begin
        tests_failed++; $display("FAIL unlock_cnt%0d: got %0d want %0d", i, bus.digit_cnt, want[i]);
      end
      if (i == 3) begin
        tests_run++; if (bus.lock !== 1'b0) begin tests_failed++; $display("FAIL unlock_lock: got %b want 0", bus.lock); end
      end
      tick('0, 0, 0);
    end
    tick('0, 1, 0);
    tests_run++; if (bus.lock !== 1'b1) begin tests_failed++; $display("FAIL unlock_close: got %b want 1", bus.lock); end
    tick('0, 0, 0);
  endtask

  task automatic test_lockout();
    int seq[4] = '{5, 9, 6, 3};
    int n;
    bit lock_ok;
    logic [9:0] k;
    for (int f = 1; f <= 3; f++) begin
      enter3(5, 9, 6);
      tick(key(4), 0, 0);
      tests_run++; if (bus.err !== 1'b1) begin tests_failed++; $display("FAIL lockout_err%0d: got %b want 1", f, bus.err); end
      tests_run++; if (bus.lock !== 1'b1) begin tests_failed++; $display("FAIL lockout_lock%0d: got %b want 1", f, bus.lock); end
      tests_run++;
      if (bus.lockout !== (f == 3)) begin
        tests_failed++; $display("FAIL lockout_flag%0d: got %b want %0d", f, bus.lockout, (f == 3));
      end
      if (f < 3) begin
        tick('0, 0, 0);
        tests_run++; if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL lockout_errpulse%0d: got %b want 0", f, bus.err); end
      end
    end
    n = 1;
    lock_ok = 1;
    for (int i = 1; i <= 60; i++) begin
      k = (i % 2 == 0) ? key(seq[(i/2) % 4]) : 10'd0;
      tick(k, 0, 0);
      if (i == 1) begin
        tests_run++; if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL lockout_errpulse3: got %b want 0", bus.err); end
      end
      if (bus.lock !== 1'b1) lock_ok = 0;
      if (bus.lockout !== 1'b1) break;
      n++;
    end
    tests_run++; if (n != LOCKOUT_CYC) begin tests_failed++; $display("FAIL lockout_len: got %0d want %0d", n, LOCKOUT_CYC); end
    tests_run++; if (!lock_ok) begin tests_failed++; $display("FAIL lockout_keys: got lock 0 want 1"); end
    tests_run++; if (bus.digit_cnt !== 3'd0) begin tests_failed++; $display("FAIL lockout_expiry_press: got %0d want 0", bus.digit_cnt); end
    tick('0, 0, 0);
    enter3(5, 9, 6);
    tick(key(3), 0, 0);
    tests_run++; if (bus.lock !== 1'b0) begin tests_failed++; $display("FAIL lockout_after: got %b want 0", bus.lock); end
    tick('0, 1, 0);
    tick('0, 0, 0);
  endtask

  task automatic test_timeout();
    bit held_ok = 1;
    tick(key(5), 0, 0); tick('0, 0, 0);
    tick(key(9), 0, 0);
    for (int i = 1; i < TIMEOUT_CYC; i++) begin
      tick('0, 0, 0);
      if (bus.digit_cnt !== 3'd2) held_ok = 0;
    end
    tests_run++; if (!held_ok) begin tests_failed++; $display("FAIL timeout_early: got %0d want 2", bus.digit_cnt); end
    tick('0, 0, 0);
    tests_run++; if (bus.digit_cnt !== 3'd0) begin tests_failed++; $display("FAIL timeout_cnt: got %0d want 0", bus.digit_cnt); end
    tests_run++; if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL timeout_err: got %b want 0", bus.err); end
    enter3(5, 9, 6);
    tick(key(3), 0, 0);
    tests_run++; if (bus.lock !== 1'b0) begin tests_failed++; $display("FAIL timeout_unlock: got %b want 0", bus.lock); end
    tick('0, 1, 0);
    tick('0, 0, 0);
  endtask

  task automatic test_glitch();
    tick(10'b0000100001, 0, 0);
    tests_run++; if (bus.digit_cnt !== 3'd0) begin tests_failed++; $display("FAIL glitch_multi: got %0d want 0", bus.digit_cnt); end
    tick('0, 0, 0); tick('0, 0, 0); tick('0, 0, 0);
    tests_run++; if (bus.digit_cnt !== 3'd0) begin tests_failed++; $display("FAIL glitch_zero: got %0d want 0", bus.digit_cnt); end
    for (int i = 0; i < 8; i++) tick(key(5), 0, 0);
    tests_run++; if (bus.digit_cnt !== 3'd1) begin tests_failed++; $display("FAIL glitch_held: got %0d want 1", bus.digit_cnt); end
    for (int i = 0; i < 5; i++) tick('0, 0, 0);
    tests_run++; if (bus.digit_cnt !== 3'd0) begin tests_failed++; $display("FAIL glitch_abort: got %0d want 0", bus.digit_cnt); end
  endtask

  task automatic test_fail_clear();
    for (int f = 0; f < 2; f++) begin
      enter3(5, 9, 6);
      tick(key(4), 0, 0);
      tests_run++; if (bus.err !== 1'b1) begin tests_failed++; $display("FAIL clear_err%0d: got %b want 1", f, bus.err); end
      tick('0, 0, 0);
    end
    enter3(5, 9, 6);
    tick(key(3), 0, 0);
    tests_run++; if (bus.lock !== 1'b0) begin tests_failed++; $display("FAIL clear_unlock: got %b want 0", bus.lock); end
    tick('0, 0, 0);
    tick(key(7), 1, 0);
    tests_run++; if (bus.lock !== 1'b1) begin tests_failed++; $display("FAIL clear_close_press: got %b want 1", bus.lock); end
    tests_run++; if (bus.digit_cnt !== 3'd0) begin tests_failed++; $display("FAIL clear_close_cnt: got %0d want 0", bus.digit_cnt); end
    tick('0, 0, 0);
    for (int f = 0; f < 2; f++) begin
      enter3(1, 2, 3);
      tick(key(4), 0, 0);
      tests_run++; if (bus.lockout !== 1'b0) begin tests_failed++; $display("FAIL clear_nolockout%0d: got %b want 0", f, bus.lockout); end
      tick('0, 0, 0);
    end
  endtask

  task automatic test_reset_mid();
    enter3(5, 9, 6);
    tests_run++; if (bus.digit_cnt !== 3'd3) begin tests_failed++; $display("FAIL rstmid_pre: got %0d want 3", bus.digit_cnt); end
    tick('0, 0, 1);
    tests_run++; if (bus.digit_cnt !== 3'd0) begin tests_failed++; $display("FAIL rstmid_cnt: got %0d want 0", bus.digit_cnt); end
    tests_run++; if (bus.lock !== 1'b1) begin tests_failed++; $display("FAIL rstmid_lock: got %b want 1", bus.lock); end
    for (int f = 0; f < 3; f++) begin
      enter3(5, 9, 6);
      tick(key(2), 0, 0);
      tick('0, 0, 0);
    end
    tests_run++; if (bus.lockout !== 1'b1) begin tests_failed++; $display("FAIL rstmid_enter_lockout: got %b want 1", bus.lockout); end
    for (int i = 0; i < 5; i++) tick('0, 0, 0);
    tick('0, 0, 1);
    tests_run++; if (bus.lockout !== 1'b0) begin tests_failed++; $display("FAIL rstmid_lockout: got %b want 0", bus.lockout); end
    tests_run++; if (bus.lock !== 1'b1) begin tests_failed++; $display("FAIL rstmid_lock2: got %b want 1", bus.lock); end
    tick('0, 0, 0);
    enter3(5, 9, 6);
    tick(key(3), 0, 0);
    tests_run++; if (bus.lock !== 1'b0) begin tests_failed++; $display("FAIL rstmid_unlock: got %b want 0", bus.lock); end
    tick('0, 1, 0);
    tick('0, 0, 0);
  endtask

  task automatic test_random();
    logic [9:0] k;
    logic [5:0] exp_out;
    logic [5:0] got_out;
    int r;
    bit c;
    bit rs;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      k = '0;
      else if (r < 75) k = key(secret_digit(m_digits.size()));
      else if (r < 88) k = key($urandom_range(0, 9));
      else             k = 10'($urandom);
      c  = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 299) == 0);
      tick(k, c, rs);
      exp_out = model_out();
      got_out = {bus.lock, bus.lockout, bus.err, bus.digit_cnt};
      tests_run++;
      if (got_out !== exp_out) begin
        tests_failed++;
        $display("FAIL random_cyc%0d: got lock/lockout/err/cnt %b want %b", cyc, got_out, exp_out);
      end
    end
  endtask

  initial begin
    bus.tenkey = '0;
    bus.close  = 1'b0;
    reset      = 1'b0;
    test_reset();
    test_unlock();
    test_lockout();
    test_timeout();
    test_glitch();
    test_fail_clear();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/elelock_seq_ctrl.md
# elelock_seq_ctrl

Four-digit code-entry controller for the electronic lock. It watches the one-hot ten-key pad and turns each new key press into a digit, then checks a complete 4-digit sequence against a secret code. A correct code drives the lock open; `close` relocks it. Repeated wrong codes trigger a timed lockout, and an idle partial entry is abandoned after a timeout. It sits between the raw ten-key switches and the lock actuator, replacing single-key unlock with a sequenced one.

## Interface
- `SECRET`, 16'h5963: four BCD digits; [15:12] is entered first, [3:0] last. A nibble above 9 never matches.
- `MAX_FAIL`, 3: consecutive wrong codes that trigger lockout (≥1).
- `LOCKOUT_CYC`, 1000: lockout duration in clk cycles (≥2).
- `TIMEOUT_CYC`, 500: idle cycles after which a partial entry is abandoned (≥2).
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `tenkey` input 10: key switches; bit i set means key i is held.
- `close` input 1: door-closed request; relocks when unlocked.
- `lock` output 1: 1 means locked.
- `lockout` output 1: 1 while in lockout.
- `err` output 1: one-cycle pulse on a wrong 4-digit code.
- `digit_cnt` output 3: digits accepted in the current entry (0–3).

## Operation
- Press detection:
  - `tenkey_q` is a registered copy of `tenkey` (reset value 0).
  - `press` is true when `tenkey` is exactly one-hot and `tenkey_q` == 0.
  - Multi-bit, zero, or held patterns never produce a press. Key i encodes to digit i.
- States: LOCKED, ENTRY, UNLOCKED, LOCKOUT.
- Reset values: state LOCKED, `lock`=1, `lockout`=0, `err`=0, `digit_cnt`=0, fail count 0, both timers 0, `tenkey_q`=0.
- LOCKED, press: store the digit, set `digit_cnt`=1, go to ENTRY, clear the idle timer.
- ENTRY, press with `digit_cnt` < 3: store the digit, increment `digit_cnt`, clear the idle timer.
- ENTRY, press with `digit_cnt` == 3: compare the 3 stored digits plus the current digit against `SECRET`.
  - Match: go to UNLOCKED, `lock`=0, fail count 0, `digit_cnt`=0.
  - Mismatch: `err`=1 for one cycle, `digit_cnt`=0, fail count +1.
    - If the new fail count == `MAX_FAIL`: go to LOCKOUT, load the lockout timer, clear the fail count.
    - Otherwise: go to LOCKED.
- ENTRY timeout: with no press, the idle timer increments each cycle. `TIMEOUT_CYC` cycles after the last press, go to LOCKED with `digit_cnt`=0. The fail count is unchanged and `err` stays 0.
- UNLOCKED:
  - Presses are ignored; `tenkey_q` still updates.
  - `close`=1 goes to LOCKED with `lock`=1.
- LOCKED/ENTRY/LOCKOUT: `close` has no effect.
- LOCKOUT:
  - `lockout`=1 and `lock`=1. Presses are ignored.
  - The timer decrements each cycle; at expiry the block returns to LOCKED.
- Counters use the minimum width for their maximum value. Counters never wrap: saturation or reload is explicit as above.

## Timing
- A press sampled at edge E takes effect at edge E. `digit_cnt` and `lock` are registered, so they are visible after E.
- Correct 4th digit at E: `lock` reads 0 in the cycle following E (1-cycle latency).
- Wrong 4th digit at E: `err` is high for exactly the cycle following E.
- Lockout entered at E: `lockout`=1 for exactly `LOCKOUT_CYC` cycles. At E+`LOCKOUT_CYC` the state is LOCKED. A press exactly at that edge is ignored.
- Timeout: last press at E and no further press means abort at edge E+`TIMEOUT_CYC`. A press at that same edge wins and is accepted as the next digit.
- `close` high at E in UNLOCKED: `lock`=1 after E, even if a press occurs at E.
- `reset` at any edge, mid-entry or mid-lockout, forces all reset values at that edge. It overrides every other event.
- Holding a key produces a single press. A new press requires one all-zero `tenkey` sample first.

## Test plan
Bench parameters: `SECRET`=16'h5963, `MAX_FAIL`=3, `LOCKOUT_CYC`=20, `TIMEOUT_CYC`=10.

1. Press keys 5,9,6,3, each separated by an all-zero cycle -> `digit_cnt` steps 1,2,3,0; `lock`=0 the cycle after the 4th press. Then `close`=1 -> `lock`=1 next cycle.
2. Enter 5,9,6,4 -> `err` high for exactly one cycle, `lock` stays 1. Repeat twice more -> on the 3rd failure `lockout`=1 for exactly 20 cycles; keys 5,9,6,3 entered during lockout leave `lock`=1; afterwards 5,9,6,3 unlocks.
3. Enter 5,9 and then idle 10 cycles -> `digit_cnt` returns to 0 with no `err`. Enter 5,9,6,3 -> unlocks, proving the fail count was unaffected.
4. Patterns 10'b0000100001, 10'b0 held, and key 5 held for 8 cycles -> exactly one digit accepted (`digit_cnt`=1).
5. Two wrong codes, then the correct code -> unlock, and the fail count clears. Two more wrong codes -> no lockout.
6. `reset` asserted after 3 digits and again mid-lockout -> `lock`=1, `lockout`=0, `digit_cnt`=0 after that edge. A full correct code then unlocks.
